// File: rtl/accel_frame_scheduler.sv
// Sequences X/Y/Z reads from an accelerometer reader and streams each sample set as a byte frame.
// Optional build macro FRAME_CHECKSUM_EN appends an XOR checksum of the six sample bytes.
module accel_frame_scheduler #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000,
    parameter logic [7:0]  HEADER_BYTE    = 8'hA5
) (
    input  logic        CLK_50,
    input  logic        iRSTN,
    input  logic        iENABLE,
    output logic [2:0]  oDIMENSION,
    output logic        oRD_REQ,
    input  logic        iRD_DONE,
    input  logic [15:0] iDATA,
    output logic [7:0]  oTX_DATA,
    output logic        oTX_VALID,
    input  logic        iTX_READY,
    output logic        oBUSY,
    output logic        oTIMEOUT,
    output logic [7:0]  oFRAME_CNT
);

`ifdef FRAME_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd7;
`else
    localparam logic [2:0] LAST_IDX = 3'd6;
`endif

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_TX} state_t;

    state_t      state;
    logic [1:0]  axis;
    logic [15:0] sample_x;
    logic [15:0] sample_y;
    logic [15:0] sample_z;
    logic [19:0] wait_cnt;
    logic [2:0]  byte_idx;
    logic [2:0]  next_idx;
    logic [7:0]  next_byte;
    logic [15:0] capture;
    logic        wait_done;
    logic        timed_out;

`ifdef FRAME_CHECKSUM_EN
    logic [7:0] checksum;
    assign checksum = sample_x[7:0] ^ sample_x[15:8] ^ sample_y[7:0] ^
                      sample_y[15:8] ^ sample_z[7:0] ^ sample_z[15:8];
`endif

    assign oBUSY    = (state != S_IDLE);
    assign next_idx = byte_idx + 3'd1;

    // A real answer on the terminal count wins over the timeout.
    always_comb begin
        wait_done = 1'b0;
        timed_out = 1'b0;
        capture   = iDATA;
        if (iRD_DONE) begin
            wait_done = 1'b1;
        end else if (wait_cnt == TIMEOUT_CYCLES - 20'd1) begin
            wait_done = 1'b1;
            timed_out = 1'b1;
            capture   = 16'h0000;
        end
    end

    always_comb begin
        next_byte = HEADER_BYTE;
        case (next_idx)
            3'd1: next_byte = sample_x[7:0];
            3'd2: next_byte = sample_x[15:8];
            3'd3: next_byte = sample_y[7:0];
            3'd4: next_byte = sample_y[15:8];
            3'd5: next_byte = sample_z[7:0];
            3'd6: next_byte = sample_z[15:8];
`ifdef FRAME_CHECKSUM_EN
            3'd7: next_byte = checksum;
`endif
            default: next_byte = HEADER_BYTE;
        endcase
    end

    always_ff @(posedge CLK_50 or negedge iRSTN) begin
        if (!iRSTN) begin
            state      <= S_IDLE;
            axis       <= 2'd0;
            oDIMENSION <= 3'd0;
            oRD_REQ    <= 1'b0;
            oTX_DATA   <= 8'd0;
            oTX_VALID  <= 1'b0;
            oTIMEOUT   <= 1'b0;
            oFRAME_CNT <= 8'd0;
            sample_x   <= 16'd0;
            sample_y   <= 16'd0;
            sample_z   <= 16'd0;
            wait_cnt   <= 20'd0;
            byte_idx   <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iENABLE) begin
                        state      <= S_REQ;
                        axis       <= 2'd0;
                        oDIMENSION <= 3'd0;
                        oRD_REQ    <= 1'b1;
                    end
                end
                S_REQ: begin
                    oRD_REQ  <= 1'b0;
                    wait_cnt <= 20'd0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_done) begin
                        case (axis)
                            2'd0:    sample_x <= capture;
                            2'd1:    sample_y <= capture;
                            default: sample_z <= capture;
                        endcase
                        if (timed_out) begin
                            oTIMEOUT <= 1'b1;
                        end
                        if (axis == 2'd2) begin
                            state     <= S_TX;
                            byte_idx  <= 3'd0;
                            oTX_DATA  <= HEADER_BYTE;
                            oTX_VALID <= 1'b1;
                        end else begin
                            axis       <= axis + 2'd1;
                            oDIMENSION <= {1'b0, axis + 2'd1};
                            oRD_REQ    <= 1'b1;
                            state      <= S_REQ;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 20'd1;
                    end
                end
                S_TX: begin
                    // oTX_VALID is always high here, so READY alone marks a handshake.
                    if (iTX_READY) begin
                        if (byte_idx == LAST_IDX) begin
                            oTX_VALID  <= 1'b0;
                            oFRAME_CNT <= oFRAME_CNT + 8'd1;
                            if (iENABLE) begin
                                state      <= S_REQ;
                                axis       <= 2'd0;
                                oDIMENSION <= 3'd0;
                                oRD_REQ    <= 1'b1;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            byte_idx <= next_idx;
                            oTX_DATA <= next_byte;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accel_frame_scheduler.sv
// Scoreboard bench for accel_frame_scheduler: a reader model feeds samples and queues the
// frame bytes it expects; a monitor pops and compares every accepted byte.
module tb_accel_frame_scheduler;

    localparam logic [19:0] TMO = 20'd16;
    localparam logic [7:0]  HDR = 8'hA5;

    logic        CLK_50;
    logic        iRSTN;
    logic        iENABLE;
    logic [2:0]  oDIMENSION;
    logic        oRD_REQ;
    logic        iRD_DONE;
    logic [15:0] iDATA;
    logic [7:0]  oTX_DATA;
    logic        oTX_VALID;
    logic        iTX_READY;
    logic        oBUSY;
    logic        oTIMEOUT;
    logic [7:0]  oFRAME_CNT;

    typedef struct {
        logic [7:0] data;
        bit         last;
    } exp_byte_t;

    exp_byte_t   exp_q[$];
    logic [15:0] directed_q[$];
    logic [15:0] samples[3];
    int          errors = 0;
    int          checks = 0;
    int          model_frames = 0;
    int          req_count = 0;
    int          tx_pos = 0;
    int          ready_mode = 0;
    int          rd_axis = 0;
    bit          exp_timeout = 0;
    bit          silent_y = 0;
    bit          y_req_seen = 0;

    accel_frame_scheduler #(
        .TIMEOUT_CYCLES(TMO),
        .HEADER_BYTE(HDR)
    ) dut (
        .CLK_50(CLK_50),
        .iRSTN(iRSTN),
        .iENABLE(iENABLE),
        .oDIMENSION(oDIMENSION),
        .oRD_REQ(oRD_REQ),
        .iRD_DONE(iRD_DONE),
        .iDATA(iDATA),
        .oTX_DATA(oTX_DATA),
        .oTX_VALID(oTX_VALID),
        .iTX_READY(iTX_READY),
        .oBUSY(oBUSY),
        .oTIMEOUT(oTIMEOUT),
        .oFRAME_CNT(oFRAME_CNT)
    );

    initial begin
        CLK_50 = 1'b0;
        forever #5 CLK_50 = ~CLK_50;
    end

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic report_expired(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got no event expected event within bound", name);
    endtask

    // Frame contents straight from the byte-order rule, independent of any FSM detail.
    task automatic push_frame(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        logic [7:0] b[$];
        b = '{HDR, x[7:0], x[15:8], y[7:0], y[15:8], z[7:0], z[15:8]};
`ifdef FRAME_CHECKSUM_EN
        b.push_back(x[7:0] ^ x[15:8] ^ y[7:0] ^ y[15:8] ^ z[7:0] ^ z[15:8]);
`endif
        foreach (b[i]) begin
            exp_q.push_back('{data: b[i], last: (i == b.size() - 1)});
        end
    endtask

    // Reader model: answers each request after 1-4 cycles, or stays silent on a forced Y timeout.
    initial begin
        logic [15:0] sample;
        int          lat;
        iRD_DONE = 1'b0;
        iDATA    = 16'h0;
        forever begin
            @(negedge CLK_50);
            if (!iRSTN) begin
                rd_axis     = 0;
                exp_timeout = 0;
            end else if (oRD_REQ) begin
                check_output("rd_dimension", {13'd0, oDIMENSION}, rd_axis[15:0]);
                req_count++;
                if (rd_axis == 1) y_req_seen = 1;
                if (rd_axis == 1 && silent_y) begin
                    silent_y    = 0;
                    sample      = 16'h0000;
                    exp_timeout = 1;
                end else begin
                    sample = (directed_q.size() > 0) ? directed_q.pop_front() : 16'($urandom);
                    lat = $urandom_range(1, 4);
                    repeat (lat) @(posedge CLK_50);
                    #1;
                    iRD_DONE = 1'b1;
                    iDATA    = sample;
                    @(posedge CLK_50);
                    #1;
                    iRD_DONE = 1'b0;
                    iDATA    = 16'($urandom);
                end
                samples[rd_axis] = sample;
                if (rd_axis == 2) begin
                    push_frame(samples[0], samples[1], samples[2]);
                    rd_axis = 0;
                end else begin
                    rd_axis++;
                end
            end
        end
    end

    initial begin
        bit pat[4];
        int ph;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        ph = 0;
        iTX_READY = 1'b1;
        forever begin
            @(posedge CLK_50);
            #1;
            case (ready_mode)
                0:       iTX_READY = 1'b1;
                1:       iTX_READY = 1'($urandom_range(0, 1));
                default: begin
                    iTX_READY = pat[ph];
                    ph = (ph + 1) % 4;
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard on each handshake, checks hold while stalled and frame-end state.
    initial begin
        exp_byte_t   e;
        bit          hold_pending;
        bit          done_pending;
        logic [7:0]  hold_data;
        hold_pending = 0;
        done_pending = 0;
        hold_data    = 8'h0;
        forever begin
            @(negedge CLK_50);
            if (!iRSTN) begin
                exp_q.delete();
                model_frames = 0;
                tx_pos       = 0;
                hold_pending = 0;
                done_pending = 0;
            end else begin
                if (hold_pending) begin
                    check_output("tx_hold_valid", {15'd0, oTX_VALID}, 16'd1);
                    check_output("tx_hold_data", {8'd0, oTX_DATA}, {8'd0, hold_data});
                end
                if (done_pending) begin
                    done_pending = 0;
                    check_output("tx_valid_drop", {15'd0, oTX_VALID}, 16'd0);
                    check_output("frame_cnt", {8'd0, oFRAME_CNT}, {8'd0, 8'(model_frames)});
                    check_output("timeout_flag", {15'd0, oTIMEOUT}, {15'd0, exp_timeout});
                end
                if (oTX_VALID && iTX_READY) begin
                    if (exp_q.size() == 0) begin
                        check_output("tx_unexpected", {8'd0, oTX_DATA}, 16'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("tx_byte", {8'd0, oTX_DATA}, {8'd0, e.data});
                        tx_pos++;
                        if (e.last) begin
                            model_frames++;
                            tx_pos       = 0;
                            done_pending = 1;
                        end
                    end
                end
                hold_pending = oTX_VALID && !iTX_READY;
                hold_data    = oTX_DATA;
            end
        end
    end

    task automatic wait_frames(input int n);
        int target;
        target = model_frames + n;
        for (int i = 0; i < 400 * n; i++) begin
            @(negedge CLK_50);
            if (model_frames >= target) return;
        end
        report_expired("frame_wait");
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_busy"}, {15'd0, oBUSY}, 16'd0);
        check_output({tag, "_rd_req"}, {15'd0, oRD_REQ}, 16'd0);
        check_output({tag, "_dimension"}, {13'd0, oDIMENSION}, 16'd0);
        check_output({tag, "_tx_valid"}, {15'd0, oTX_VALID}, 16'd0);
        check_output({tag, "_tx_data"}, {8'd0, oTX_DATA}, 16'd0);
        check_output({tag, "_timeout"}, {15'd0, oTIMEOUT}, 16'd0);
        check_output({tag, "_frame_cnt"}, {8'd0, oFRAME_CNT}, 16'd0);
    endtask

    task automatic apply_stimulus();
        int rc;
        bit found;

        iRSTN   = 1'b0;
        iENABLE = 1'b0;
        repeat (3) @(negedge CLK_50);
        check_reset_values("reset");
        @(posedge CLK_50);
        #1;
        iRSTN = 1'b1;
        repeat (3) @(negedge CLK_50);
        check_output("idle_busy", {15'd0, oBUSY}, 16'd0);

        // Known sample set first, then random data under random and 1-0-0-1 back-pressure.
        directed_q = '{16'h1234, 16'hABCD, 16'h0F0F};
        ready_mode = 0;
        iENABLE = 1'b1;
        wait_frames(1);
        ready_mode = 1;
        wait_frames(5);
        ready_mode = 2;
        wait_frames(3);

        ready_mode = 1;
        silent_y = 1'b1;
        wait_frames(3);
        check_output("timeout_sticky", {15'd0, oTIMEOUT}, 16'd1);

        ready_mode = 0;
        y_req_seen = 1'b0;
        found = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge CLK_50);
            #1;
            if (y_req_seen) begin
                found = 1;
                break;
            end
        end
        if (!found) report_expired("y_request_wait");
        iENABLE = 1'b0;
        wait_frames(1);
        rc = req_count;
        repeat (30) @(negedge CLK_50);
        check_output("stop_busy", {15'd0, oBUSY}, 16'd0);
        check_output("stop_no_req", 16'(req_count), 16'(rc));

        iENABLE = 1'b1;
        found = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge CLK_50);
            #2;
            if (oTX_VALID && tx_pos == 3) begin
                found = 1;
                break;
            end
        end
        if (!found) report_expired("tx_byte3_wait");
        iRSTN = 1'b0;
        #1;
        check_reset_values("midframe_reset");
        repeat (3) @(negedge CLK_50);
        @(posedge CLK_50);
        #1;
        iRSTN = 1'b1;
        wait_frames(2);

        found = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge CLK_50);
            if (model_frames >= 256) begin
                found = 1;
                break;
            end
        end
        if (!found) report_expired("wrap_wait");
        @(negedge CLK_50);
        check_output("frame_cnt_wrap", {8'd0, oFRAME_CNT}, 16'd0);

        iENABLE = 1'b0;
        found = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK_50);
            if (!oBUSY) begin
                found = 1;
                break;
            end
        end
        if (!found) report_expired("final_idle_wait");
        repeat (2) @(negedge CLK_50);
        check_output("leftover_bytes", 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        apply_stimulus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
